// File: rtl/valid_pattern_checker_mc_if.sv
// Purpose: bundles the control, data and result signals of the multi-channel
//          VALTRAIN checker so the sequencer and checker share one port.
// Ports:   master = training sequencer side, slave = checker side.
interface valid_pattern_checker_mc_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 12,
    parameter int BEAT_W = 8
);
    logic                       i_start;
    logic                       i_mode;
    logic [CNT_W-1:0]           i_consec_target;
    logic [BEAT_W-1:0]          i_max_beats;
    logic [ERR_W-1:0]           i_err_threshold;
    logic                       i_abort;
    logic                       i_data_valid;
    logic [NUM_CH*DATA_W-1:0]   i_rvld;
    logic                       i_done_ack;
    logic                       o_busy;
    logic                       o_done;
    logic [NUM_CH-1:0]          o_pass;
    logic [NUM_CH*ERR_W-1:0]    o_err_count;
    logic [BEAT_W-1:0]          o_beat_count;
    logic [NUM_CH-1:0]          o_frame_match;

    modport master (
        output i_start, i_mode, i_consec_target, i_max_beats, i_err_threshold,
               i_abort, i_data_valid, i_rvld, i_done_ack,
        input  o_busy, o_done, o_pass, o_err_count, o_beat_count, o_frame_match
    );

    modport slave (
        input  i_start, i_mode, i_consec_target, i_max_beats, i_err_threshold,
               i_abort, i_data_valid, i_rvld, i_done_ack,
        output o_busy, o_done, o_pass, o_err_count, o_beat_count, o_frame_match
    );
endinterface

// File: rtl/valid_pattern_checker_mc.sv
// Purpose: checks NUM_CH valid-lane streams against the repeating 8'hF0 unit,
//          either for a consecutive-match target (CONSEC) or by counting bit
//          errors over a fixed number of beats (ITER).
// Ports:   i_clk/i_rst plain (sync, active-high); everything else on the slave
//          modport of valid_pattern_checker_mc_if. Results are registered and
//          appear the cycle after the terminating beat; held until i_done_ack.
module valid_pattern_checker_mc #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 12,
    parameter int BEAT_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    valid_pattern_checker_mc_if.slave vp
);
    localparam int                 UNITS    = DATA_W / 8;
    localparam logic [7:0]         UNIT_PAT = 8'hF0;
    localparam logic [DATA_W-1:0]  WORD_PAT = {UNITS{UNIT_PAT}};
    localparam logic [CNT_W-1:0]   RUN_MAX  = '1;
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [BEAT_W-1:0]   max_beats_q, max_beats_d;
    logic [ERR_W-1:0]    thresh_q, thresh_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [NUM_CH-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]    run_q [NUM_CH];
    logic [CNT_W-1:0]    run_d [NUM_CH];
    logic [ERR_W-1:0]    err_q [NUM_CH];
    logic [ERR_W-1:0]    err_d [NUM_CH];

    // Per-beat candidate values, only committed when the beat is consumed.
    logic [CNT_W-1:0]    beat_run [NUM_CH];
    logic [ERR_W-1:0]    beat_err [NUM_CH];
    logic [NUM_CH-1:0]   beat_hit;

    // Walk the units oldest to newest, carrying the run in from the previous
    // beat. Checking the target after every unit catches a run anywhere in
    // the beat; the final run is the trailing-match count (or run+UNITS when
    // the whole word matched) that carries into the next beat.
    always_comb begin
        logic [DATA_W-1:0] word;
        logic [CNT_W-1:0]  run;
        logic              hit;
        logic [ERR_W:0]    esum;
        word     = '0;
        run      = '0;
        hit      = 1'b0;
        esum     = '0;
        beat_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            word = vp.i_rvld[c*DATA_W +: DATA_W];
            run  = run_q[c];
            hit  = (run >= target_q);
            for (int k = 0; k < UNITS; k++) begin
                if (word[8*k +: 8] == UNIT_PAT) begin
                    if (run != RUN_MAX) begin
                        run = run + 1'b1;
                    end
                end else begin
                    run = '0;
                end
                hit = hit | (run >= target_q);
            end
            beat_run[c] = run;
            beat_hit[c] = hit;
            // One extra bit catches the carry out so the count clamps, never wraps.
            esum        = {1'b0, err_q[c]} + (ERR_W+1)'($countones(word ^ WORD_PAT));
            beat_err[c] = esum[ERR_W] ? ERR_MAX : esum[ERR_W-1:0];
        end
    end

    always_comb begin
        logic [BEAT_W-1:0] beat_inc;
        state_d     = state_q;
        mode_d      = mode_q;
        target_d    = target_q;
        max_beats_d = max_beats_q;
        thresh_d    = thresh_q;
        beat_d      = beat_q;
        pass_d      = pass_q;
        run_d       = run_q;
        err_d       = err_q;
        beat_inc    = beat_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (vp.i_start) begin
                    state_d     = S_RUN;
                    mode_d      = vp.i_mode;
                    target_d    = vp.i_consec_target;
                    max_beats_d = vp.i_max_beats;
                    thresh_d    = vp.i_err_threshold;
                    beat_d      = '0;
                    pass_d      = '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        run_d[c] = '0;
                        err_d[c] = '0;
                    end
                end
            end
            S_RUN: begin
                if (max_beats_q == '0) begin
                    // Zero-length run: finish without touching the data. ITER
                    // has zero errors; CONSEC only passes a zero target.
                    state_d = S_DONE;
                    pass_d  = (mode_q || (target_q == '0)) ? '1 : '0;
                end else if (vp.i_data_valid) begin
                    beat_d = beat_inc;
                    if (mode_q) begin
                        err_d = beat_err;
                        if (beat_inc == max_beats_q) begin
                            state_d = S_DONE;
                            for (int c = 0; c < NUM_CH; c++) begin
                                pass_d[c] = (beat_err[c] <= thresh_q);
                            end
                        end
                    end else begin
                        run_d  = beat_run;
                        pass_d = pass_q | beat_hit;
                        if ((&(pass_q | beat_hit)) || (beat_inc == max_beats_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (vp.i_done_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything except reset.
        if (vp.i_abort) begin
            state_d = S_IDLE;
            beat_d  = '0;
            pass_d  = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                run_d[c] = '0;
                err_d[c] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            target_q    <= '0;
            max_beats_q <= '0;
            thresh_q    <= '0;
            beat_q      <= '0;
            pass_q      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                run_q[c] <= '0;
                err_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            max_beats_q <= max_beats_d;
            thresh_q    <= thresh_d;
            beat_q      <= beat_d;
            pass_q      <= pass_d;
            for (int c = 0; c < NUM_CH; c++) begin
                run_q[c] <= run_d[c];
                err_q[c] <= err_d[c];
            end
        end
    end

    assign vp.o_busy       = (state_q == S_RUN);
    assign vp.o_done       = (state_q == S_DONE);
    assign vp.o_pass       = pass_q;
    assign vp.o_beat_count = beat_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign vp.o_err_count[c*ERR_W +: ERR_W] = err_q[c];
        assign vp.o_frame_match[c] = (vp.i_rvld[c*DATA_W +: DATA_W] == WORD_PAT);
    end
endmodule

// File: tb/tb_valid_pattern_checker_mc.sv
module tb_valid_pattern_checker_mc;
    localparam int DATA_W  = 32;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int ERR_W   = 12;
    localparam int BEAT_W  = 8;
    localparam int UNITS   = DATA_W / 8;
    localparam int ERR_SAT = (1 << ERR_W) - 1;
    localparam logic [DATA_W-1:0] PAT_WORD = {UNITS{8'hF0}};

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [DATA_W-1:0] span_seq [4];

    always #5 clk = ~clk;

    valid_pattern_checker_mc_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W),
                                  .ERR_W(ERR_W), .BEAT_W(BEAT_W)) vp ();

    valid_pattern_checker_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W),
                               .ERR_W(ERR_W), .BEAT_W(BEAT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .vp    (vp)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind 0: mostly-clean random units; 1: ch1 all zero; 2: ch0 one error bit/beat;
    // 3: inverted pattern everywhere; 4: fixed span sequence on ch0, ch1 zero.
    function automatic logic [DATA_W-1:0] gen_word(int kind, int ch, int beat);
        logic [DATA_W-1:0] w;
        w = '0;
        case (kind)
            2: w = (ch == 0) ? 32'hF0F0_F0F1 : PAT_WORD;
            3: w = 32'h0F0F_0F0F;
            4: w = (ch == 0) ? span_seq[beat % 4] : '0;
            default: begin
                if (!(kind == 1 && ch == 1)) begin
                    for (int k = 0; k < UNITS; k++) begin
                        w[8*k +: 8] = ($urandom_range(99) < 82) ? 8'hF0 : 8'($urandom);
                    end
                end
            end
        endcase
        return w;
    endfunction

    task automatic idle_inputs();
        vp.i_start = 0; vp.i_mode = 0; vp.i_consec_target = '0; vp.i_max_beats = '0;
        vp.i_err_threshold = '0; vp.i_abort = 0; vp.i_data_valid = 0; vp.i_rvld = '0;
        vp.i_done_ack = 0;
    endtask

    task automatic check_cleared(input string name);
        check_val({name, "/busy"},  vp.o_busy, 0);
        check_val({name, "/done"},  vp.o_done, 0);
        check_val({name, "/pass"},  vp.o_pass, 0);
        check_val({name, "/err"},   vp.o_err_count, 0);
        check_val({name, "/beats"}, vp.o_beat_count, 0);
    endtask

    // Launches one check and follows it with a reference model built straight
    // from the rules: an unbounded streak of matching units per channel and an
    // unbounded error sum clamped only when compared.
    task automatic run_check(input string name, input bit mode, input int target, input int maxb,
                             input int thresh, input int kind, input int vld_pct, input int hold,
                             input int abort_after);
        int   streak [NUM_CH];
        int   merr   [NUM_CH];
        bit   mpass  [NUM_CH];
        int   mbeats, cyc;
        bit   term, vld, allp;
        logic [DATA_W-1:0] w [NUM_CH];
        logic [NUM_CH-1:0] exp_pass, exp_fm;
        logic [NUM_CH*ERR_W-1:0] exp_err;

        for (int c = 0; c < NUM_CH; c++) begin streak[c] = 0; merr[c] = 0; mpass[c] = 0; end
        mbeats = 0; cyc = 0; term = 0;

        vp.i_mode = mode; vp.i_consec_target = CNT_W'(target); vp.i_max_beats = BEAT_W'(maxb);
        vp.i_err_threshold = ERR_W'(thresh); vp.i_start = 1;
        @(posedge clk); @(negedge clk);
        vp.i_start = 0;
        check_val({name, "/busy_after_start"}, {vp.o_busy, vp.o_done}, 2'b10);

        while (!term && cyc < 2000) begin
            if (cyc == abort_after) begin
                vp.i_abort = 1; vp.i_data_valid = 1;
                @(posedge clk); @(negedge clk);
                vp.i_abort = 0; vp.i_data_valid = 0;
                check_cleared({name, "/abort"});
                return;
            end
            vld = ($urandom_range(99) < vld_pct);
            for (int c = 0; c < NUM_CH; c++) begin
                w[c] = gen_word(kind, c, mbeats);
                vp.i_rvld[c*DATA_W +: DATA_W] = w[c];
                exp_fm[c] = (w[c] == PAT_WORD);
            end
            vp.i_data_valid = vld;
            #1;
            check_val({name, "/frame_match"}, vp.o_frame_match, exp_fm);

            if (maxb == 0) begin
                term = 1;
                for (int c = 0; c < NUM_CH; c++) mpass[c] = mode || (target == 0);
            end else if (vld) begin
                mbeats++;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!mode) begin
                        if (target == 0) mpass[c] = 1;
                        for (int k = 0; k < UNITS; k++) begin
                            streak[c] = (w[c][8*k +: 8] == 8'hF0) ? streak[c] + 1 : 0;
                            if (streak[c] >= target) mpass[c] = 1;
                        end
                    end else begin
                        merr[c] += $countones(w[c] ^ PAT_WORD);
                    end
                end
                allp = 1;
                for (int c = 0; c < NUM_CH; c++) allp &= mpass[c];
                term = (mbeats == maxb) || (!mode && allp);
                if (mode && term)
                    for (int c = 0; c < NUM_CH; c++) mpass[c] = ((merr[c] > ERR_SAT ? ERR_SAT : merr[c]) <= thresh);
            end
            @(posedge clk); @(negedge clk);
            cyc++;
            check_val({name, "/busy_done"}, {vp.o_busy, vp.o_done}, term ? 2'b01 : 2'b10);
        end
        vp.i_data_valid = 0;
        check_val({name, "/terminated"}, term, 1);

        for (int c = 0; c < NUM_CH; c++) begin
            exp_pass[c] = mpass[c];
            exp_err[c*ERR_W +: ERR_W] = mode ? ERR_W'(merr[c] > ERR_SAT ? ERR_SAT : merr[c]) : '0;
        end
        check_val({name, "/pass"},  vp.o_pass, exp_pass);
        check_val({name, "/err"},   vp.o_err_count, exp_err);
        check_val({name, "/beats"}, vp.o_beat_count, mbeats);

        // Results must hold in DONE; a start pulse here must be ignored.
        for (int h = 0; h < hold; h++) begin
            vp.i_start = 1'($urandom_range(1));
            @(posedge clk); @(negedge clk);
            check_val({name, "/hold_done"},  {vp.o_busy, vp.o_done}, 2'b01);
            check_val({name, "/hold_pass"},  vp.o_pass, exp_pass);
            check_val({name, "/hold_err"},   vp.o_err_count, exp_err);
            check_val({name, "/hold_beats"}, vp.o_beat_count, mbeats);
        end
        vp.i_start = 0; vp.i_done_ack = 1;
        @(posedge clk); @(negedge clk);
        vp.i_done_ack = 0;
        check_val({name, "/ack_idle"},  {vp.o_busy, vp.o_done}, 2'b00);
        check_val({name, "/idle_pass"}, vp.o_pass, exp_pass);
        check_val({name, "/idle_err"},  vp.o_err_count, exp_err);
    endtask

    initial begin
        span_seq[0] = 32'hF0F0_F000; span_seq[1] = 32'hF0F0_F0F0;
        span_seq[2] = 32'hF0F0_F0F0; span_seq[3] = 32'h0000_00F0;
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 0;
        @(posedge clk); @(negedge clk);
        check_cleared("post_reset");

        run_check("consec_timeout", 0, 16, 4,   0,    1, 60, 1,  -1);
        run_check("consec_span",    0, 16, 8,   0,    4, 80, 1,  -1);
        run_check("iter_thr128",    1, 0,  128, 128,  2, 75, 2,  -1);

        // Start and abort together in IDLE: abort wins and clears held results.
        vp.i_start = 1; vp.i_abort = 1; vp.i_max_beats = 8'd5;
        @(posedge clk); @(negedge clk);
        vp.i_start = 0; vp.i_abort = 0;
        check_cleared("start_abort_idle");

        run_check("iter_thr127",    1, 0,  128, 127,  2, 75, 0,  -1);
        run_check("iter_saturate",  1, 0,  255, 100,  3, 90, 0,  -1);
        run_check("handshake_hold", 0, 8,  10,  0,    0, 80, 10, -1);
        run_check("abort_run",      1, 0,  50,  10,   3, 80, 0,  5);
        run_check("maxb0_iter",     1, 3,  0,   0,    3, 50, 1,  -1);
        run_check("maxb0_consec",   0, 5,  0,   0,    0, 50, 1,  -1);
        run_check("maxb0_tgt0",     0, 0,  0,   0,    1, 50, 0,  -1);
        run_check("consec_tgt0",    0, 0,  5,   0,    1, 40, 0,  -1);

        // Synchronous reset in the middle of a run.
        vp.i_mode = 0; vp.i_consec_target = 8'd16; vp.i_max_beats = 8'd100; vp.i_start = 1;
        @(posedge clk); @(negedge clk);
        vp.i_start = 0;
        for (int b = 0; b < 2; b++) begin
            vp.i_data_valid = 1; vp.i_rvld = {2{PAT_WORD}};
            @(posedge clk); @(negedge clk);
        end
        check_val("mid_run_busy", vp.o_beat_count, 2);
        rst = 1; vp.i_data_valid = 0;
        @(posedge clk); @(negedge clk);
        rst = 0;
        check_cleared("reset_mid_run");

        for (int i = 0; i < 25; i++) begin
            run_check("random", 1'($urandom_range(1)), $urandom_range(12), $urandom_range(20),
                      $urandom_range(40), 0, 70, $urandom_range(3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
